// File: rtl/byteswap_pkg.sv
// Shared types and constants for the byte-swap lane swapper.
package byteswap_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_SWAP16 = 2'd1,
    MODE_SWAP32 = 2'd2,
    MODE_SWAP64 = 2'd3
  } swap_mode_e;

  typedef enum logic {
    PKT_START = 1'b0,
    IN_PKT    = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/byteswap_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Head entry is read combinationally from the register file.
module byteswap_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             s_axis_aclk,
  input  logic             s_axis_aresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_wr, do_rd;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      level <= level + 1'b1;
      else if (do_rd && !do_wr) level <= level - 1'b1;
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/byteswap_lane_swapper.sv
// AXI4-Stream byte swapper: per-packet swap mode, 2-stage pipe into an FWFT FIFO.
// Optional packet statistics ports when BYTESWAP_PKT_STATS_EN is defined.
module byteswap_lane_swapper
  import byteswap_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_FIFO_DEPTH       = 32,
  parameter int C_DEFAULT_MODE     = 2
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic [1:0]                      ctrl_mode,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
`ifdef BYTESWAP_PKT_STATS_EN
  output logic [31:0]                     stat_beats,
  output logic [31:0]                     stat_pkts,
`endif
  output logic [$clog2(C_FIFO_DEPTH):0]   fifo_level
);

  localparam int NB     = C_AXIS_TDATA_WIDTH / BYTE_W;
  localparam int IW     = $clog2(NB);
  localparam int STAGES = 2;
  localparam int FW     = C_AXIS_TDATA_WIDTH + NB + 1;

  pkt_state_e                   state_q, state_d;
  swap_mode_e                   mode_sel, active_mode_q, s1_mode;
  logic [STAGES:1]              vld_pipe;
  logic                         acc, rd, tready_q, tready_d, init_q;
  int                           occ_next;
  logic [NB-1:0][BYTE_W-1:0]    s1_data, s2_data, sw_data;
  logic [NB-1:0]                s1_keep, s2_keep, sw_keep;
  logic                         s1_last, s2_last;
  logic [2:0]                   mask;
  logic [IW-1:0]                idx;
  logic [FW-1:0]                head;
  logic                         fifo_empty;

  assign acc           = s_axis_tvalid & tready_q;
  assign rd            = m_axis_tvalid & m_axis_tready;
  assign s_axis_tready = tready_q;

  // FSM: state register / next state / mode selection
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) state_q <= PKT_START;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (acc) state_d = s_axis_tlast ? PKT_START : IN_PKT;
  end

  always_comb begin
    mode_sel = active_mode_q;
    if (state_q == PKT_START) mode_sel = swap_mode_e'(ctrl_mode);
  end

  // Ready looks at next cycle's occupancy so an accepted beat always has a slot.
  always_comb begin
    occ_next = int'(fifo_level) + int'(vld_pipe[1]) + int'(vld_pipe[2])
             + int'(acc) - int'(rd);
    tready_d = init_q && (occ_next <= C_FIFO_DEPTH - 3);
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      vld_pipe      <= '0;
      active_mode_q <= swap_mode_e'(2'(C_DEFAULT_MODE));
      tready_q      <= 1'b0;
      init_q        <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      if (acc && state_q == PKT_START) active_mode_q <= mode_sel;
      init_q   <= 1'b1;
      tready_q <= tready_d;
    end
  end

  // Word of 2^k bytes reversed == byte index XOR (2^k - 1); mode 0 gives mask 0.
  assign mask = 3'((4'd1 << s1_mode) - 4'd1);

  always_comb begin
    sw_data = s1_data;
    sw_keep = s1_keep;
    idx     = '0;
    for (int b = 0; b < NB; b++) begin
      idx        = IW'(b) ^ IW'(mask);
      sw_data[b] = s1_data[idx];
      sw_keep[b] = s1_keep[idx];
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (acc) begin
      s1_data <= s_axis_tdata;
      s1_keep <= s_axis_tkeep;
      s1_last <= s_axis_tlast;
      s1_mode <= mode_sel;
    end
    if (vld_pipe[1]) begin
      s2_data <= sw_data;
      s2_keep <= sw_keep;
      s2_last <= s1_last;
    end
  end

  byteswap_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .s_axis_aclk    (s_axis_aclk),
    .s_axis_aresetn (s_axis_aresetn),
    .wr_en          (vld_pipe[STAGES]),
    .wr_data        ({s2_last, s2_keep, s2_data}),
    .rd_en          (rd),
    .rd_data        (head),
    .empty          (fifo_empty),
    .level          (fifo_level)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = head[C_AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tkeep  = head[C_AXIS_TDATA_WIDTH +: NB];
  assign m_axis_tlast  = head[FW-1];

`ifdef BYTESWAP_PKT_STATS_EN
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      stat_beats <= '0;
      stat_pkts  <= '0;
    end else if (vld_pipe[STAGES]) begin
      stat_beats <= stat_beats + 32'd1;
      if (s2_last) stat_pkts <= stat_pkts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_byteswap_lane_swapper.sv
// Self-checking bench for byteswap_lane_swapper (W=64, depth 32) against a
// queue-based reference model of per-packet byte reversal.
module tb_byteswap_lane_swapper;

  localparam int W = 64, NB = W / 8, DEPTH = 32, LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    ctrl_mode;
  logic          s_tvalid, s_tready, s_tlast;
  logic [W-1:0]  s_tdata;
  logic [NB-1:0] s_tkeep;
  logic          m_tvalid, m_tready, m_tlast;
  logic [W-1:0]  m_tdata;
  logic [NB-1:0] m_tkeep;
  logic [LW-1:0] fifo_level;
`ifdef BYTESWAP_PKT_STATS_EN
  logic [31:0]   stat_beats, stat_pkts;
`endif

  always #5 clk = ~clk;

  byteswap_lane_swapper #(
    .C_AXIS_TDATA_WIDTH (W),
    .C_FIFO_DEPTH       (DEPTH),
    .C_DEFAULT_MODE     (2)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .ctrl_mode      (ctrl_mode),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tlast   (s_tlast),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
`ifdef BYTESWAP_PKT_STATS_EN
    .stat_beats     (stat_beats),
    .stat_pkts      (stat_pkts),
`endif
    .fifo_level     (fifo_level)
  );

  typedef struct packed {
    logic [W-1:0]  d;
    logic [NB-1:0] k;
    logic          l;
  } beat_t;

  beat_t      exp_q[$], got_q[$];
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0;
  bit         mdl_inpkt = 0;
  logic [1:0] mdl_mode = 2'd2;

  always @(posedge clk) cyc <= cyc + 1;

  // Output handshake completes at the following posedge.
  always @(negedge clk)
    if (rst_n && m_tvalid && m_tready) got_q.push_back({m_tdata, m_tkeep, m_tlast});

  // Reference: each group of 2^mode bytes is written back in reverse order.
  function automatic beat_t ref_swap(input beat_t b, input logic [1:0] mode);
    int    n;
    beat_t r;
    n = 1 << mode;
    r = b;
    for (int w = 0; w < NB / n; w++)
      for (int j = 0; j < n; j++) begin
        r.d[(w*n + n-1-j)*8 +: 8] = b.d[(w*n + j)*8 +: 8];
        r.k[w*n + n-1-j]          = b.k[w*n + j];
      end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [W-1:0] d, input logic [NB-1:0] k, input logic l);
    int    t = 0;
    bit    ok = 0;
    beat_t b;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    while (!ok && t < 500) begin
      @(negedge clk);
      if (s_tready) ok = 1; else t++;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout got=no_ready required=ready_within_500");
    end else begin
      if (!mdl_inpkt) mdl_mode = ctrl_mode;
      b.d = d; b.k = k; b.l = l;
      exp_q.push_back(ref_swap(b, mdl_mode));
      mdl_inpkt = !l;
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 2000) begin
      @(posedge clk); t++;
    end
    repeat (4) @(posedge clk);
    #1;
    ok = (got_q.size() >= exp_q.size());
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); got_q.delete(); mdl_inpkt = 0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    m_tready = 1'b1; ctrl_mode = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid got=%b required=0", m_tvalid); end
    n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_sready got=%b required=0", s_tready); end
    n_chk++; if (fifo_level !== '0) begin n_fail++; $display("FAIL rst_level got=%0d required=0", fifo_level); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_edge1 got=%b required=0", s_tready); end
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_later got=%b required=1", s_tready); end
  endtask

  task automatic test_single_beat();
    bit ok;
    exp_q.delete(); got_q.delete();
    ctrl_mode = 2'd2; m_tready = 1'b1;
    send_beat(64'h0011223344556677, 8'hFF, 1'b1);
    n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL lat_e0 got=%b required=0", m_tvalid); end
    @(posedge clk); #1;
    n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL lat_e1 got=%b required=0", m_tvalid); end
    @(posedge clk); #1;
    n_chk++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL lat_e2 got=%b required=1", m_tvalid); end
    n_chk++; if (m_tdata !== 64'h3322110077665544) begin n_fail++; $display("FAIL sw32_data got=%h required=3322110077665544", m_tdata); end
    n_chk++; if (m_tlast !== 1'b1) begin n_fail++; $display("FAIL sw32_last got=%b required=1", m_tlast); end
    n_chk++; if (fifo_level !== LW'(1)) begin n_fail++; $display("FAIL sw32_level got=%0d required=1", fifo_level); end
    wait_drain(ok);
    n_chk++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL sw32_model got_n=%0d required_n=1", got_q.size()); end
  endtask

  task automatic test_mode3_keep();
    bit ok;
    exp_q.delete(); got_q.delete();
    ctrl_mode = 2'd3;
    send_beat(64'h0011223344556677, 8'h0F, 1'b1);
    wait_drain(ok);
    n_chk++; if (got_q.size() != 1) begin n_fail++; $display("FAIL sw64_count got=%0d required=1", got_q.size()); end
    else begin
      n_chk++; if (got_q[0].k !== 8'hF0) begin n_fail++; $display("FAIL sw64_keep got=%h required=f0", got_q[0].k); end
      n_chk++; if (got_q[0].d !== 64'h7766554433221100) begin n_fail++; $display("FAIL sw64_data got=%h required=7766554433221100", got_q[0].d); end
      n_chk++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL sw64_model got=%h required=%h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_mode_hold();
    bit           ok;
    logic [W-1:0] sent [6];
    exp_q.delete(); got_q.delete();
    ctrl_mode = 2'd1;
    for (int i = 0; i < 6; i++) begin
      sent[i] = {$urandom, $urandom};
      if (i == 2) ctrl_mode = 2'd0;
      send_beat(sent[i], 8'hFF, (i == 3) || (i == 5));
    end
    wait_drain(ok);
    n_chk++; if (got_q.size() != 6) begin n_fail++; $display("FAIL hold_count got=%0d required=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hold_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 6) begin
      n_chk++; if (got_q[3].d !== {sent[3][55:48], sent[3][63:56], sent[3][39:32], sent[3][47:40],
                                   sent[3][23:16], sent[3][31:24], sent[3][7:0], sent[3][15:8]}) begin
        n_fail++; $display("FAIL hold_beat3_sw16 got=%h sent=%h", got_q[3].d, sent[3]); end
      n_chk++; if (got_q[4].d !== sent[4]) begin n_fail++; $display("FAIL hold_next_pass got=%h required=%h", got_q[4].d, sent[4]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int c0;
    exp_q.delete(); got_q.delete();
    ctrl_mode = 2'd1; m_tready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) ctrl_mode = 2'($urandom);
      send_beat({$urandom, $urandom}, 8'($urandom), (i % 6) == 5);
    end
    n_chk++; if (cyc - c0 != 24) begin n_fail++; $display("FAIL b2b_cycles got=%0d required=24", cyc - c0); end
    wait_drain(ok);
    n_chk++; if (got_q.size() != 24) begin n_fail++; $display("FAIL b2b_count got=%0d required=24", got_q.size()); end
    for (int i = 0; i < 24 && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    bit rnd_done = 0;
    exp_q.delete(); got_q.delete();
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          ctrl_mode = 2'($urandom);
          if ($urandom % 4 == 0) begin @(posedge clk); #1; end
          send_beat({$urandom, $urandom}, 8'($urandom), (i == 149) || ($urandom % 4 == 0));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          m_tready = ($urandom % 4) != 0;
        end
        m_tready = 1'b1;
      end
    join
    wait_drain(ok);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit            ok;
    bit            seen_low = 0;
    int            max_lvl = 0;
    beat_t         h0, h1;
    exp_q.delete(); got_q.delete();
    ctrl_mode = 2'd2; m_tready = 1'b0;
    fork
      for (int i = 0; i < 40; i++) send_beat({$urandom, $urandom}, 8'($urandom), i == 39);
      begin
        for (int c = 0; c < 80; c++) begin
          @(negedge clk);
          if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
          if (!s_tready) seen_low = 1;
          if (c == 5)  h0 = {m_tdata, m_tkeep, m_tlast};
          if (c == 70) h1 = {m_tdata, m_tkeep, m_tlast};
        end
        n_chk++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held got=%b required=1", m_tvalid); end
        n_chk++; if (h1 !== h0) begin n_fail++; $display("FAIL bp_head_stable got=%h required=%h", h1, h0); end
        @(posedge clk); #1;
        m_tready = 1'b1;
      end
    join
    wait_drain(ok);
    n_chk++; if (!seen_low) begin n_fail++; $display("FAIL bp_ready_drop got=never_low required=low"); end
    n_chk++; if (max_lvl > DEPTH) begin n_fail++; $display("FAIL bp_max_level got=%0d required<=%0d", max_lvl, DEPTH); end
    n_chk++; if (got_q.size() != 40) begin n_fail++; $display("FAIL bp_count got=%0d required=40", got_q.size()); end
    for (int i = 0; i < 40 && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_q.delete(); got_q.delete();
    ctrl_mode = 2'd1; m_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (fifo_level !== LW'(3)) begin n_fail++; $display("FAIL rm_level_pre got=%0d required=3", fifo_level); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rm_mvalid got=%b required=0", m_tvalid); end
    n_chk++; if (fifo_level !== '0) begin n_fail++; $display("FAIL rm_level got=%0d required=0", fifo_level); end
    n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rm_sready got=%b required=0", s_tready); end
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); got_q.delete(); mdl_inpkt = 0;
    rst_n = 1'b1; m_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_chk++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rm_stale got=%0d required=0", got_q.size()); end
    ctrl_mode = 2'd3;
    send_beat(64'h0011223344556677, 8'h0F, 1'b0);
    send_beat(64'h8899AABBCCDDEEFF, 8'hFF, 1'b1);
    wait_drain(ok);
    n_chk++; if (got_q.size() != 2) begin n_fail++; $display("FAIL rm_post_count got=%0d required=2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rm_post%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

`ifdef BYTESWAP_PKT_STATS_EN
  task automatic test_stats();
    bit ok;
    do_reset();
    n_chk++; if (stat_beats !== 32'd0) begin n_fail++; $display("FAIL st_beats_rst got=%0d required=0", stat_beats); end
    m_tready = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 5; i++) send_beat({$urandom, $urandom}, 8'hFF, i == 4);
    wait_drain(ok);
    n_chk++; if (stat_beats !== 32'd15) begin n_fail++; $display("FAIL st_beats got=%0d required=15", stat_beats); end
    n_chk++; if (stat_pkts !== 32'd3) begin n_fail++; $display("FAIL st_pkts got=%0d required=3", stat_pkts); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_mode3_keep();
    test_mode_hold();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_reset_mid();
`ifdef BYTESWAP_PKT_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/byteswap_lane_swapper.md
BYTESWAP_LANE_SWAPPER -- requirements
Module: byteswap_lane_swapper

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 512: data width of both streams; a multiple of 64, minimum 64.
REQ-002 SHALL have parameter C_FIFO_DEPTH, default 32: output FIFO entries; a power of two, minimum 8.
REQ-003 SHALL have parameter C_DEFAULT_MODE, default 2: swap mode in force after reset until the first packet start.
REQ-004 SHALL have port s_axis_aclk, input, 1: the single clock for all logic.
REQ-005 SHALL have port s_axis_aresetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port ctrl_mode, input, 2: swap mode; 0 pass-through, 1 swap within 16-bit words, 2 within 32-bit, 3 within 64-bit.
REQ-007 SHALL have ports s_axis_tvalid/tready/tdata/tkeep/tlast: input/output/input/input/input, widths 1/1/W/W/8/1; AXI4-Stream slave.
REQ-008 SHALL have ports m_axis_tvalid/tready/tdata/tkeep/tlast: output/input/output/output/output, same widths; AXI4-Stream master.
REQ-009 SHALL have port fifo_level, output, clog2(C_FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-010 SHALL, in mode k>0 with word size 2^k bytes, move byte j of each word to byte (2^k-1-j) of the same word, for tdata and tkeep together.
REQ-011 SHALL pass tdata and tkeep unmodified in mode 0; tlast is never modified.
REQ-012 SHALL run a two-state FSM, PKT_START and IN_PKT, reset to PKT_START.
REQ-013 SHALL sample ctrl_mode only on an accepted beat in PKT_START, and apply it to that beat and to every beat through its tlast.
REQ-014 SHALL move PKT_START->IN_PKT on an accepted beat with tlast=0, and IN_PKT->PKT_START on an accepted beat with tlast=1; an accepted single beat with tlast=1 stays in PKT_START.
REQ-015 SHALL ignore ctrl_mode changes while in IN_PKT.
REQ-016 SHALL accept a beat only when s_axis_tvalid and s_axis_tready are both 1, and SHALL write it to the FIFO exactly two edges later (stage 1: capture, stage 2: swap).
REQ-017 SHALL drive s_axis_tready from a register, high only when FIFO occupancy plus beats in flight in stages 1-2 is at most C_FIFO_DEPTH-3, so no accepted beat is ever dropped.
REQ-018 SHALL present the FIFO head first-word-fall-through: m_axis_tvalid rises on the edge that writes into an empty FIFO, giving 2-cycle acceptance-to-output latency.
REQ-019 SHALL hold m_axis_tdata/tkeep/tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 SHALL allow a FIFO read and write in the same cycle, including at full and at empty, with fifo_level unchanged and no loss; pointers wrap modulo C_FIFO_DEPTH.
REQ-021 SHALL sustain one beat per cycle when m_axis_tready is held high.

Reset
REQ-022 SHALL, on s_axis_aresetn=0, immediately force m_axis_tvalid=0, s_axis_tready=0, fifo_level=0, FSM=PKT_START, active mode=C_DEFAULT_MODE, and clear stage valids and FIFO pointers.
REQ-023 SHALL discard all in-flight and buffered beats on reset mid-packet, with no partial beat emitted afterwards.
REQ-024 SHALL raise s_axis_tready no earlier than the second edge after reset deassertion.

Configuration
REQ-025 SHALL, with BYTESWAP_PKT_STATS_EN defined, add 32-bit outputs stat_beats and stat_pkts that count beats and tlast beats written to the FIFO, wrap modulo 2^32 and reset to 0.
REQ-026 SHALL, without BYTESWAP_PKT_STATS_EN, have neither the stats ports nor the stats logic.

Structure
REQ-027 SHALL take the mode encodings, the FSM state type and the BYTE_W=8 constant from shared package byteswap_pkg.
REQ-028 SHALL instantiate its FIFO as sub-module byteswap_sync_fifo, a single-clock FWFT FIFO with level output and no vendor primitives.

Verification
REQ-029 SHALL check: mode 2, W=64, tdata 0x0011223344556677 with tlast -> output 0x3322110077665544 after 2 cycles.
REQ-030 SHALL check: mode 3 with tkeep 0x0F -> tkeep 0xF0, and tdata 0x0011223344556677 -> 0x7766554433221100.
REQ-031 SHALL check: a 4-beat packet in mode 1 with ctrl_mode switched to 0 at beat 2 -> all 4 beats 16-bit swapped, and the next packet passed through.
REQ-032 SHALL check: m_axis_tready=0 while 40 beats are offered, depth 32 -> tready drops, fifo_level never exceeds 32, then all 40 beats emerge in order with no loss.
REQ-033 SHALL check: reset asserted after beat 3 of 6 -> m_axis_tvalid=0 at once and no old beats appear after reset release.
REQ-034 SHALL check: BYTESWAP_PKT_STATS_EN defined, 3 packets of 5 beats -> stat_beats=15 and stat_pkts=3.
